// File: rtl/approx_mult_err_monitor.sv
// Error-statistics monitor for unsigned approximate multipliers: accumulates |x*y - z_approx| over a window.
// Optional macro ERR_SQ_ACC_EN adds sq_sum, the saturating sum of squared error distances.
module approx_mult_err_monitor #(
    parameter int W           = 8,
    parameter int NUM_SAMPLES = 65536,
    parameter int CNT_W       = 17,
    parameter int ACC_W       = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           x,
    input  logic [W-1:0]           y,
    input  logic [2*W-1:0]         z_approx,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       samples,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [2*W-1:0]         err_max,
    output logic [ACC_W-1:0]       err_sum,
`ifdef ERR_SQ_ACC_EN
    output logic [ACC_W+2*W-1:0]   sq_sum,
`endif
    output logic [1:0]             fsm_state
);

    localparam int PW    = 2 * W;
    localparam int ACC1  = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SAMPLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    // Handshake: a sample transfers on a rising edge where in_valid and in_ready are both
    // high; in_ready is registered, so it never depends combinationally on in_valid.
    logic             accept;
    logic             last_accept;
    logic             clear_stats;
    logic [CNT_W-1:0] samples_inc;

    logic             s1_valid;
    logic [W-1:0]     s1_x;
    logic [W-1:0]     s1_y;
    logic [PW-1:0]    s1_z;
    logic [PW-1:0]    exact;
    logic [PW-1:0]    ed_comb;

    logic             s2_valid;
    logic [PW-1:0]    s2_ed;
    logic [ACC1-1:0]  sum_ext;

    assign accept      = in_valid & in_ready;
    assign samples_inc = samples + 1'b1;
    assign last_accept = accept && (samples_inc == LAST);
    assign fsm_state   = state;

    always_comb begin
        state_next  = state;
        clear_stats = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next  = RUN;
                    clear_stats = 1'b1;
                end
            end
            RUN: begin
                if (last_accept) state_next = DRAIN;
            end
            DRAIN: begin
                // S2 retires into S3 on the same edge, so an empty S1 means the window is final.
                if (!s1_valid) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == RUN);
            busy     <= (state_next == RUN) || (state_next == DRAIN);
            done     <= (state_next == DONE);
        end
    end

    // S1: operand capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_z     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_x <= x;
                s1_y <= y;
                s1_z <= z_approx;
            end
        end
    end

    // S2: exact product and error distance in either direction
    assign exact   = PW'(s1_x) * PW'(s1_y);
    assign ed_comb = (exact >= s1_z) ? (exact - s1_z) : (s1_z - exact);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_ed    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_ed    <= ed_comb;
        end
    end

    // S3: statistics; the extra sum bit catches the carry that triggers saturation
    assign sum_ext = {1'b0, err_sum} + ACC1'(s2_ed);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samples <= '0;
            err_cnt <= '0;
            err_max <= '0;
            err_sum <= '0;
        end else if (clear_stats) begin
            samples <= '0;
            err_cnt <= '0;
            err_max <= '0;
            err_sum <= '0;
        end else begin
            if (accept) samples <= samples_inc;
            if (s2_valid) begin
                err_sum <= sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
                if (s2_ed > err_max) err_max <= s2_ed;
                if (s2_ed != '0) err_cnt <= err_cnt + 1'b1;
            end
        end
    end

`ifdef ERR_SQ_ACC_EN
    localparam int SQ_W  = ACC_W + PW;
    localparam int SQ4   = 2 * PW;
    localparam int SQ_W1 = SQ_W + 1;

    logic [SQ4-1:0]   ed_sq;
    logic [SQ_W1-1:0] sq_ext;

    assign ed_sq  = SQ4'(s2_ed) * SQ4'(s2_ed);
    assign sq_ext = {1'b0, sq_sum} + SQ_W1'(ed_sq);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_sum <= '0;
        end else if (clear_stats) begin
            sq_sum <= '0;
        end else if (s2_valid) begin
            sq_sum <= sq_ext[SQ_W] ? {SQ_W{1'b1}} : sq_ext[SQ_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed bench for approx_mult_err_monitor: three instances (default, 4-sample, 16-bit accumulator).
module tb_approx_mult_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  x, y;
    logic [15:0] z;
    logic        start_a, start_b, start_c;

    logic        in_ready_a, busy_a, done_a;
    logic [16:0] samples_a, err_cnt_a;
    logic [15:0] err_max_a;
    logic [39:0] err_sum_a;
    logic [1:0]  fsm_a;

    logic        in_ready_b, busy_b, done_b;
    logic [16:0] samples_b, err_cnt_b;
    logic [15:0] err_max_b;
    logic [39:0] err_sum_b;
    logic [1:0]  fsm_b;

    logic        in_ready_c, busy_c, done_c;
    logic [16:0] samples_c, err_cnt_c;
    logic [15:0] err_max_c;
    logic [15:0] err_sum_c;
    logic [1:0]  fsm_c;

`ifdef ERR_SQ_ACC_EN
    logic [55:0] sq_sum_a, sq_sum_b;
    logic [31:0] sq_sum_c;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int sel     = 0;
    int lat;
    logic rdy_sel, done_sel;

    // clock / reset block
    always #5 clk = ~clk;

    approx_mult_err_monitor dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(in_ready_a),
        .x(x), .y(y), .z_approx(z), .busy(busy_a), .done(done_a), .samples(samples_a),
        .err_cnt(err_cnt_a), .err_max(err_max_a), .err_sum(err_sum_a),
`ifdef ERR_SQ_ACC_EN
        .sq_sum(sq_sum_a),
`endif
        .fsm_state(fsm_a)
    );

    approx_mult_err_monitor #(.NUM_SAMPLES(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .x(x), .y(y), .z_approx(z), .busy(busy_b), .done(done_b), .samples(samples_b),
        .err_cnt(err_cnt_b), .err_max(err_max_b), .err_sum(err_sum_b),
`ifdef ERR_SQ_ACC_EN
        .sq_sum(sq_sum_b),
`endif
        .fsm_state(fsm_b)
    );

    approx_mult_err_monitor #(.NUM_SAMPLES(2), .ACC_W(16)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .in_valid(in_valid), .in_ready(in_ready_c),
        .x(x), .y(y), .z_approx(z), .busy(busy_c), .done(done_c), .samples(samples_c),
        .err_cnt(err_cnt_c), .err_max(err_max_c), .err_sum(err_sum_c),
`ifdef ERR_SQ_ACC_EN
        .sq_sum(sq_sum_c),
`endif
        .fsm_state(fsm_c)
    );

    always_comb begin
        rdy_sel  = 1'b0;
        done_sel = 1'b0;
        case (sel)
            0: begin rdy_sel = in_ready_a; done_sel = done_a; end
            1: begin rdy_sel = in_ready_b; done_sel = done_b; end
            2: begin rdy_sel = in_ready_c; done_sel = done_c; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // driver: one sample, held until the selected instance accepts it
    task automatic send(input logic [7:0] xv, input logic [7:0] yv, input logic [15:0] zv);
        int guard = 0;
        @(negedge clk);
        x = xv; y = yv; z = zv; in_valid = 1'b1;
        while (!rdy_sel && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("accept_timeout", 64'(rdy_sel), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse_start(input int which);
        @(negedge clk);
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_sel && n < 200);
        check("done_seen", 64'(done_sel), 64'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; z = '0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_in_ready", 64'(in_ready_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_fsm", 64'(fsm_a), 64'd0);
        check("rst_samples", 64'(samples_a), 64'd0);
        check("rst_err_sum", 64'(err_sum_a), 64'd0);
        check("rst_err_max", 64'(err_max_a), 64'd0);
        check("rst_err_cnt", 64'(err_cnt_a), 64'd0);

        // exhaustive exact products on the default instance
        sel = 0;
        pulse_start(0);
        check("t1_busy", 64'(busy_a), 64'd1);
        for (int xi = 0; xi < 256; xi++)
            for (int yi = 0; yi < 256; yi++)
                send(8'(xi), 8'(yi), 16'(xi * yi));
        wait_done(lat);
        check("t1_samples", 64'(samples_a), 64'd65536);
        check("t1_err_sum", 64'(err_sum_a), 64'd0);
        check("t1_err_max", 64'(err_max_a), 64'd0);
        check("t1_err_cnt", 64'(err_cnt_a), 64'd0);
        check("t1_busy_end", 64'(busy_a), 64'd0);

        // four mixed samples, done latency
        sel = 1;
        pulse_start(1);
        send(8'd3, 8'd5, 16'd18);
        send(8'd2, 8'd2, 16'd4);
        send(8'd10, 8'd10, 16'd97);
        send(8'd255, 8'd255, 16'd0);
        wait_done(lat);
        check("t2_done_latency", 64'(lat), 64'd3);
        check("t2_err_sum", 64'(err_sum_b), 64'd65031);
        check("t2_err_max", 64'(err_max_b), 64'd65025);
        check("t2_err_cnt", 64'(err_cnt_b), 64'd3);
        check("t2_samples", 64'(samples_b), 64'd4);
        check("t2_busy", 64'(busy_b), 64'd0);
        check("t2_fsm_done", 64'(fsm_b), 64'd3);

        // valid every other cycle, z off by one
        pulse_start(1);
        send(8'd1, 8'd1, 16'd2);
        @(posedge clk);
        send(8'd4, 8'd5, 16'd21);
        @(posedge clk);
        send(8'd7, 8'd9, 16'd64);
        check("t3_ready_before_last", 64'(in_ready_b), 64'd1);
        @(posedge clk);
        send(8'd200, 8'd100, 16'd20001);
        check("t3_ready_after_last", 64'(in_ready_b), 64'd0);
        wait_done(lat);
        check("t3_samples", 64'(samples_b), 64'd4);
        check("t3_err_sum", 64'(err_sum_b), 64'd4);
        check("t3_err_cnt", 64'(err_cnt_b), 64'd4);
        check("t3_err_max", 64'(err_max_b), 64'd1);

        // start mid-RUN is ignored
        pulse_start(1);
        send(8'd3, 8'd3, 16'd9);
        send(8'd2, 8'd3, 16'd7);
        pulse_start(1);
        check("t4_fsm_run", 64'(fsm_b), 64'd1);
        check("t4_samples_kept", 64'(samples_b), 64'd2);
        send(8'd4, 8'd4, 16'd16);
        send(8'd5, 8'd5, 16'd20);
        wait_done(lat);
        check("t4_samples", 64'(samples_b), 64'd4);
        check("t4_err_sum", 64'(err_sum_b), 64'd6);
        check("t4_err_cnt", 64'(err_cnt_b), 64'd2);
        check("t4_err_max", 64'(err_max_b), 64'd5);

        // reset mid-RUN aborts, then a clean window
        pulse_start(1);
        send(8'd9, 8'd9, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4r_fsm", 64'(fsm_b), 64'd0);
        check("t4r_busy", 64'(busy_b), 64'd0);
        check("t4r_in_ready", 64'(in_ready_b), 64'd0);
        check("t4r_done", 64'(done_b), 64'd0);
        check("t4r_samples", 64'(samples_b), 64'd0);
        check("t4r_err_sum", 64'(err_sum_b), 64'd0);
        repeat (3) @(negedge clk);
        check("t4r_err_sum_late", 64'(err_sum_b), 64'd0);
        pulse_start(1);
        send(8'd6, 8'd7, 16'd40);
        send(8'd0, 8'd0, 16'd0);
        send(8'd1, 8'd1, 16'd1);
        send(8'd2, 8'd2, 16'd4);
        wait_done(lat);
        check("t4c_samples", 64'(samples_b), 64'd4);
        check("t4c_err_sum", 64'(err_sum_b), 64'd2);
        check("t4c_err_cnt", 64'(err_cnt_b), 64'd1);
        check("t4c_err_max", 64'(err_max_b), 64'd2);

        // 16-bit accumulator saturation
        sel = 2;
        pulse_start(2);
        send(8'd255, 8'd255, 16'd0);
        send(8'd255, 8'd255, 16'd0);
        wait_done(lat);
        check("t5_err_sum_sat", 64'(err_sum_c), 64'd65535);
        check("t5_err_max", 64'(err_max_c), 64'd65025);
        check("t5_err_cnt", 64'(err_cnt_c), 64'd2);
        check("t5_samples", 64'(samples_c), 64'd2);

        // ed=3 then ed=4 after a fresh start clears the saturated sum
        pulse_start(2);
        send(8'd1, 8'd3, 16'd0);
        send(8'd2, 8'd2, 16'd0);
        wait_done(lat);
        check("t6_err_sum", 64'(err_sum_c), 64'd7);
        check("t6_err_max", 64'(err_max_c), 64'd4);
`ifdef ERR_SQ_ACC_EN
        check("t6_sq_sum", 64'(sq_sum_c), 64'd25);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
